mcu_sequencer: RTL and testbench
================================

MCU_SEQUENCER -- requirements
Module: mcu_sequencer

Interface
REQ-001 SHALL have parameter N, default 2: number of convolution outputs per column; even, >=2.
REQ-002 SHALL have parameter STATES, default 3: number of MCU mux states.
REQ-003 SHALL have parameter IMAGE_WIDTH, default 640: columns per frame.
REQ-004 SHALL have port i_CLK, input, 1 bit: single clock, rising edge.
REQ-005 SHALL have port i_RST_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port i_start, input, 1 bit: single-cycle request to begin a frame.
REQ-007 SHALL have port i_valid, input, 1 bit: input pixel present.
REQ-008 SHALL have port o_ready, output, 1 bit: sequencer accepts a pixel.
REQ-009 SHALL have port o_valid, output, 1 bit: convolution result present.
REQ-010 SHALL have port i_ready, input, 1 bit: downstream accepts a result.
REQ-011 SHALL have port o_state, output, $clog2(STATES) bits: mux state (0 = LOAD, 1 = CONV, 2 = DRAIN).
REQ-012 SHALL have port o_substate, output, $clog2(N/2+1)+1 bits: convolution step index.
REQ-013 SHALL have port o_memSelect, output, $clog2(N+2) bits: row-memory or result select.
REQ-014 SHALL have port o_memWrEn, output, 1 bit: row-memory write strobe.
REQ-015 SHALL have port o_busy, output, 1 bit: frame in progress.
REQ-016 SHALL have port o_frameDone, output, 1 bit: one-cycle pulse when the last column drains.

Function
REQ-017 FSM SHALL have states IDLE, LOAD, CONV, DRAIN; o_state = 0 in IDLE and LOAD, 1 in CONV, 2 in DRAIN.
REQ-018 IDLE SHALL go to LOAD on i_start=1 and clear the column counter; i_start SHALL be ignored in all other states.
REQ-019 LOAD: o_ready=1; beat = i_valid & o_ready; o_memWrEn = beat (combinational); o_memSelect SHALL start at 0 and increment per beat.
REQ-020 Beat with o_memSelect = N+1 SHALL wrap o_memSelect to 0 and move to CONV next cycle.
REQ-021 CONV SHALL last exactly N/2+1 cycles, o_substate = 0..N/2, one step per cycle, with no stall; it then goes to DRAIN with o_substate cleared to 0.
REQ-022 DRAIN: o_valid=1; out-beat = o_valid & i_ready; o_memSelect SHALL start at 0 and increment per out-beat up to N-1.
REQ-023 Out-beat at o_memSelect = N-1 SHALL increment the column counter and clear o_memSelect; if column = IMAGE_WIDTH-1, it SHALL pulse o_frameDone and go to IDLE, else go to LOAD.
REQ-024 Without a beat, all counters and the state SHALL hold (i_valid=0 in LOAD, i_ready=0 in DRAIN); there is no timeout.
REQ-025 o_ready SHALL be 0 outside LOAD; o_valid SHALL be 0 outside DRAIN; o_memWrEn SHALL never assert outside LOAD.
REQ-026 o_busy SHALL be 1 in every state except IDLE.
REQ-027 Counters SHALL be sized so IMAGE_WIDTH-1 and N+1 are representable without overflow; wrap occurs only at the stated terminal values.
REQ-028 All outputs except o_memWrEn, o_ready and o_valid SHALL be registered.

Reset
REQ-029 i_RST_n=0 SHALL asynchronously force IDLE, with all counters and all outputs 0, including mid-frame; no partial frame resumes.
REQ-030 The first i_start SHALL be honoured on the first clock edge after reset deassertion.

Structure
REQ-031 FSM state encodings and mux state codes (LOAD/CONV/DRAIN) SHALL live in shared package mcu_pkg, also used by MUX_ARRAY benches.
REQ-032 A sub-module mod_counter (parameter MODULUS, with enable, clear and terminal-count output) SHALL implement the memSelect, substate and column counters.

Verification (N=2, IMAGE_WIDTH=3)
REQ-033 Reset, then i_start pulse, then continuous i_valid and i_ready -> per column: 4 LOAD cycles with memSelect 0,1,2,3 and memWrEn=1; 2 CONV cycles with substate 0,1; 2 DRAIN cycles with memSelect 0,1; o_frameDone high exactly once, after 24 cycles; then IDLE.
REQ-034 i_valid low for 5 cycles at memSelect=2 -> memSelect holds at 2, memWrEn=0, state stays LOAD.
REQ-035 i_ready low for 3 cycles in DRAIN at memSelect=1 -> o_valid holds at 1, memSelect stays 1, column counter unchanged.
REQ-036 i_start pulsed during CONV -> no effect; frame completes normally with exactly one o_frameDone.
REQ-037 i_RST_n asserted during DRAIN of column 1 -> all outputs 0 immediately; a new i_start restarts from column 0.
REQ-038 Two back-to-back frames (i_start the cycle after o_frameDone) -> second frame timing identical to the first.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared encodings for the MCU sequencer: FSM states and the mux state codes
// that the sequencer drives and the mux-array benches decode.
package mcu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CONV  = 2'd2,
    ST_DRAIN = 2'd3
  } fsm_state_e;

  typedef enum logic [1:0] {
    MUX_LOAD  = 2'd0,
    MUX_CONV  = 2'd1,
    MUX_DRAIN = 2'd2
  } mux_state_e;

  // IDLE shares the LOAD code so the mux array sits in a harmless state.
  function automatic mux_state_e mux_code(input fsm_state_e s);
    case (s)
      ST_CONV:  return MUX_CONV;
      ST_DRAIN: return MUX_DRAIN;
      default:  return MUX_LOAD;
    endcase
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MODULUS up counter with synchronous clear and a terminal-count flag.
module mod_counter #(
  parameter int MODULUS = 4,
  localparam int W = (MODULUS > 1) ? $clog2(MODULUS) : 1
) (
  input  logic         i_CLK,
  input  logic         i_RST_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  logic [W-1:0] r_count;

  // NOTE: state updates use <= so every flop samples pre-edge values together.
  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == LAST);

endmodule

// File: rtl/mcu_sequencer.sv
// Per-column sequencer: loads N+2 rows, runs N/2+1 convolution steps, then
// drains N results downstream, repeating for IMAGE_WIDTH columns per frame.
module mcu_sequencer
  import mcu_pkg::*;
#(
  parameter int N           = 2,
  parameter int STATES      = 3,
  parameter int IMAGE_WIDTH = 640
) (
  input  logic                         i_CLK,
  input  logic                         i_RST_n,
  input  logic                         i_start,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [$clog2(STATES)-1:0]    o_state,
  output logic [$clog2(N/2+1):0]       o_substate,
  output logic [$clog2(N+2)-1:0]       o_memSelect,
  output logic                         o_memWrEn,
  output logic                         o_busy,
  output logic                         o_frameDone
);

  localparam int STW   = $clog2(STATES);
  localparam int SEL_W = $clog2(N + 2);
  localparam int SUB_W = $clog2(N / 2 + 1);
  localparam int COL_W = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;

  fsm_state_e       r_state;
  fsm_state_e       w_next;
  logic [STW-1:0]   r_state_code;
  logic             r_busy;
  logic             r_frame_done;

  logic [SEL_W-1:0] w_sel;
  logic             w_sel_tc;
  logic             w_sel_en;
  logic             w_sel_clr;
  logic             w_sel_last_out;
  logic [SUB_W-1:0] w_sub;
  logic             w_sub_tc;
  logic             w_sub_en;
  logic [COL_W-1:0] w_col;
  logic             w_col_tc;
  logic             w_col_en;
  logic             w_col_clr;
  logic             w_frame_end;
  logic             w_unused_col;

  mod_counter #(.MODULUS(N + 2)) u_sel_cnt (
    .i_CLK   (i_CLK),
    .i_RST_n (i_RST_n),
    .i_en    (w_sel_en),
    .i_clr   (w_sel_clr),
    .o_count (w_sel),
    .o_tc    (w_sel_tc)
  );

  mod_counter #(.MODULUS(N / 2 + 1)) u_sub_cnt (
    .i_CLK   (i_CLK),
    .i_RST_n (i_RST_n),
    .i_en    (w_sub_en),
    .i_clr   (1'b0),
    .o_count (w_sub),
    .o_tc    (w_sub_tc)
  );

  mod_counter #(.MODULUS(IMAGE_WIDTH)) u_col_cnt (
    .i_CLK   (i_CLK),
    .i_RST_n (i_RST_n),
    .i_en    (w_col_en),
    .i_clr   (w_col_clr),
    .o_count (w_col),
    .o_tc    (w_col_tc)
  );

  // The column index itself is only consumed through its terminal count.
  assign w_unused_col   = ^w_col;
  assign w_sel_last_out = (w_sel == SEL_W'(N - 1));
  assign w_frame_end    = (r_state == ST_DRAIN) && i_ready && w_sel_last_out && w_col_tc;

  always_ff @(posedge i_CLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state      <= ST_IDLE;
      r_state_code <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_state_code <= STW'(mux_code(w_next));
      r_busy       <= (w_next != ST_IDLE);
      r_frame_done <= w_frame_end;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_LOAD;
      ST_LOAD:  if (i_valid && w_sel_tc) w_next = ST_CONV;
      ST_CONV:  if (w_sub_tc) w_next = ST_DRAIN;
      ST_DRAIN: if (i_ready && w_sel_last_out) w_next = w_col_tc ? ST_IDLE : ST_LOAD;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_memWrEn = 1'b0;
    w_sel_en  = 1'b0;
    w_sel_clr = 1'b0;
    w_sub_en  = 1'b0;
    w_col_en  = 1'b0;
    w_col_clr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_col_clr = i_start;
      end
      ST_LOAD: begin
        o_ready   = 1'b1;
        o_memWrEn = i_valid;
        w_sel_en  = i_valid;
      end
      ST_CONV: begin
        w_sub_en = 1'b1;
      end
      ST_DRAIN: begin
        o_valid = 1'b1;
        if (i_ready) begin
          if (w_sel_last_out) begin
            w_sel_clr = 1'b1;
            w_col_en  = 1'b1;
          end else begin
            w_sel_en = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign o_state     = r_state_code;
  assign o_substate  = {1'b0, w_sub};
  assign o_memSelect = w_sel;
  assign o_busy      = r_busy;
  assign o_frameDone = r_frame_done;

endmodule

// File: tb/tb_mcu_sequencer.sv
// Directed bench for mcu_sequencer with N=2, IMAGE_WIDTH=3: a cycle table for
// one full frame plus hand-written stall, restart and back-to-back sequences.
module tb_mcu_sequencer;

  logic       clk;
  logic       rst_n;
  logic       i_start;
  logic       i_valid;
  logic       i_ready;
  logic       o_ready;
  logic       o_valid;
  logic [1:0] o_state;
  logic [1:0] o_substate;
  logic [1:0] o_memSelect;
  logic       o_memWrEn;
  logic       o_busy;
  logic       o_frameDone;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_done = 0;

  mcu_sequencer #(.N(2), .STATES(3), .IMAGE_WIDTH(3)) dut (
    .i_CLK       (clk),
    .i_RST_n     (rst_n),
    .i_start     (i_start),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_state     (o_state),
    .o_substate  (o_substate),
    .o_memSelect (o_memSelect),
    .o_memWrEn   (o_memWrEn),
    .o_busy      (o_busy),
    .o_frameDone (o_frameDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (o_frameDone) n_done <= n_done + 1;
  end

  typedef struct {
    logic start, valid, ready;
    int   st, sub, sel, we, rdy, vld, busy, done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic v, input logic r,
                              input int st, input int sub, input int sel, input int we,
                              input int rdy, input int vld, input int busy, input int done);
    vec_t x;
    x.start = s;  x.valid = v;  x.ready = r;
    x.st = st;    x.sub = sub;  x.sel = sel;  x.we = we;
    x.rdy = rdy;  x.vld = vld;  x.busy = busy; x.done = done;
    return x;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".state"}, int'(o_state), 0);
    check({tag, ".sub"},   int'(o_substate), 0);
    check({tag, ".sel"},   int'(o_memSelect), 0);
    check({tag, ".we"},    int'(o_memWrEn), 0);
    check({tag, ".rdy"},   int'(o_ready), 0);
    check({tag, ".vld"},   int'(o_valid), 0);
    check({tag, ".busy"},  int'(o_busy), 0);
    check({tag, ".done"},  int'(o_frameDone), 0);
  endtask

  task automatic apply(input vec_t v, input string tag);
    i_start = v.start;
    i_valid = v.valid;
    i_ready = v.ready;
    #1;
    check({tag, ".state"}, int'(o_state), v.st);
    check({tag, ".sub"},   int'(o_substate), v.sub);
    check({tag, ".sel"},   int'(o_memSelect), v.sel);
    check({tag, ".we"},    int'(o_memWrEn), v.we);
    check({tag, ".rdy"},   int'(o_ready), v.rdy);
    check({tag, ".vld"},   int'(o_valid), v.vld);
    check({tag, ".busy"},  int'(o_busy), v.busy);
    check({tag, ".done"},  int'(o_frameDone), v.done);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; returns one cycle into LOAD.
  task automatic start_frame(output int t0, output int n0);
    i_start = 1'b1;
    i_valid = 1'b1;
    i_ready = 1'b1;
    t0 = cyc + 1;
    n0 = n_done;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  // Ends at the negedge one cycle after the done pulse.
  task automatic finish_frame(input int t0, input int n0, input int exp, input string tag);
    int n = 0;
    while (!o_frameDone && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".done_at"}, cyc - t0, exp);
    @(negedge clk);
    check({tag, ".done_clr"}, int'(o_frameDone), 0);
    check({tag, ".idle"},     int'(o_busy), 0);
    check({tag, ".n_done"},   n_done - n0, 1);
  endtask

  initial begin
    int t0, n0;
    rst_n   = 1'b0;
    i_start = 1'b0;
    i_valid = 1'b1;
    i_ready = 1'b1;

    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int c = 0; c < 3; c++) begin
      for (int m = 0; m < 4; m++) vecs.push_back(mk(0, 1, 1, 0, 0, m, 1, 1, 0, 1, 0));
      for (int s = 0; s < 2; s++) vecs.push_back(mk(0, 1, 1, 1, s, 0, 0, 0, 0, 1, 0));
      for (int m = 0; m < 2; m++) vecs.push_back(mk(0, 1, 1, 2, 0, m, 0, 0, 1, 1, 0));
    end
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));

    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Full frame, start on the first edge after reset release.
    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Input stall at memSelect=2 for five cycles.
    start_frame(t0, n0);
    repeat (2) @(negedge clk);
    i_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      check($sformatf("vstall%0d.sel", k),   int'(o_memSelect), 2);
      check($sformatf("vstall%0d.we", k),    int'(o_memWrEn), 0);
      check($sformatf("vstall%0d.state", k), int'(o_state), 0);
      check($sformatf("vstall%0d.rdy", k),   int'(o_ready), 1);
      @(negedge clk);
    end
    i_valid = 1'b1;
    #1;
    check("vstall_end.we", int'(o_memWrEn), 1);
    check("vstall_end.sel", int'(o_memSelect), 2);
    finish_frame(t0, n0, 29, "vstall");

    // Output stall in DRAIN at memSelect=1 for three cycles.
    start_frame(t0, n0);
    repeat (7) @(negedge clk);
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("rstall%0d.vld", k),   int'(o_valid), 1);
      check($sformatf("rstall%0d.sel", k),   int'(o_memSelect), 1);
      check($sformatf("rstall%0d.state", k), int'(o_state), 2);
      @(negedge clk);
    end
    i_ready = 1'b1;
    @(negedge clk);
    check("rstall_next.state", int'(o_state), 0);
    check("rstall_next.sel", int'(o_memSelect), 0);
    check("rstall_next.busy", int'(o_busy), 1);
    finish_frame(t0, n0, 27, "rstall");

    // Start pulse during CONV is ignored.
    start_frame(t0, n0);
    repeat (4) @(negedge clk);
    i_start = 1'b1;
    #1;
    check("convstart.state", int'(o_state), 1);
    check("convstart.sub", int'(o_substate), 0);
    @(negedge clk);
    i_start = 1'b0;
    #1;
    check("convstart1.sub", int'(o_substate), 1);
    finish_frame(t0, n0, 24, "convstart");

    // Asynchronous reset in DRAIN of column 1, then a fresh frame.
    start_frame(t0, n0);
    repeat (14) @(negedge clk);
    #1;
    check("midrst.pre_state", int'(o_state), 2);
    #1 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    start_frame(t0, n0);
    finish_frame(t0, n0, 24, "restart");

    // Back-to-back: second start the cycle after the done pulse.
    start_frame(t0, n0);
    finish_frame(t0, n0, 24, "b2b_first");
    start_frame(t0, n0);
    #1;
    check("b2b_second.state", int'(o_state), 0);
    check("b2b_second.busy", int'(o_busy), 1);
    finish_frame(t0, n0, 24, "b2b_second");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
